// File: rtl/ext_pkg.sv
// -----------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the immediate-extension blocks.
//   - EXT_* : encodings of the 2-bit extension mode carried with each immediate
//   - DEFAULT_NBITS / DEFAULT_EXTBITS / DEFAULT_SHIFT : default widths used as
//     parameter defaults by ext_core and imm_extend_stage
// -----------------------------------------------------------------------------
package ext_pkg;

    localparam logic [1:0] EXT_SIGN   = 2'b00;  // sign-extend
    localparam logic [1:0] EXT_ZERO   = 2'b01;  // zero-extend
    localparam logic [1:0] EXT_UPPER  = 2'b10;  // immediate placed in top bits
    localparam logic [1:0] EXT_BRANCH = 2'b11;  // sign-extend then shift left

    localparam int DEFAULT_NBITS   = 16;
    localparam int DEFAULT_EXTBITS = 32;
    localparam int DEFAULT_SHIFT   = 2;

endpackage : ext_pkg

// File: rtl/ext_core.sv
// -----------------------------------------------------------------------------
// ext_core
// Purely combinational, mode-selecting immediate extender. Supersedes the
// fixed sign extender (which is kept for its legacy users).
//
// Parameters:
//   NBITS   - raw immediate width
//   EXTBITS - result width, must be >= NBITS + SHIFT
//   SHIFT   - left shift applied in branch-offset mode
//
// Ports:
//   i_sign [NBITS-1:0]   raw immediate
//   i_mode [1:0]         extension mode (EXT_SIGN/ZERO/UPPER/BRANCH)
//   o_ext  [EXTBITS-1:0] extended result
// -----------------------------------------------------------------------------
module ext_core
    import ext_pkg::*;
#(
    parameter int NBITS   = DEFAULT_NBITS,
    parameter int EXTBITS = DEFAULT_EXTBITS,
    parameter int SHIFT   = DEFAULT_SHIFT
) (
    input  logic [NBITS-1:0]   i_sign,
    input  logic [1:0]         i_mode,
    output logic [EXTBITS-1:0] o_ext
);

    // The branch offset must fit after shifting, otherwise its top bits are lost.
    if (EXTBITS < NBITS + SHIFT) begin : g_width_check
        $error("ext_core: EXTBITS (%0d) must be >= NBITS + SHIFT (%0d)",
               EXTBITS, NBITS + SHIFT);
    end

    logic [EXTBITS-1:0] sign_ext;
    logic [EXTBITS-1:0] zero_ext;

    // Size casts keep this legal when EXTBITS == NBITS (no zero-width replication).
    assign sign_ext = EXTBITS'($signed(i_sign));
    assign zero_ext = EXTBITS'(i_sign);

    always_comb begin
        o_ext = sign_ext;
        case (i_mode)
            EXT_SIGN:   o_ext = sign_ext;
            EXT_ZERO:   o_ext = zero_ext;
            EXT_UPPER:  o_ext = zero_ext << (EXTBITS - NBITS);
            EXT_BRANCH: o_ext = sign_ext << SHIFT;
            default:    o_ext = sign_ext;
        endcase
    end

endmodule : ext_core

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
// Registered immediate-extension stage for the ID/EX boundary. The immediate
// is extended combinationally on the input side; only the result and its mode
// are registered. A valid/ready handshake with an output register (OUT) and a
// one-entry skid register (SKID) decouples upstream from downstream stalls.
// o_ready is a flop, so there is no combinational path from i_ready to o_ready.
//
// Occupancy (implicit from the valid bits): EMPTY, ONE (OUT only), FULL
// (OUT and SKID). o_ready is low exactly while FULL.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready upstream handshake, i_data + i_mode sampled on accept
//   i_flush         synchronous squash of every held entry (highest priority)
//   o_valid/i_ready downstream handshake, o_ext + o_mode held while stalled
// -----------------------------------------------------------------------------
module imm_extend_stage
    import ext_pkg::*;
#(
    parameter int NBITS   = DEFAULT_NBITS,
    parameter int EXTBITS = DEFAULT_EXTBITS,
    parameter int SHIFT   = DEFAULT_SHIFT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NBITS-1:0]   i_data,
    input  logic [1:0]         i_mode,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [EXTBITS-1:0] o_ext,
    output logic [1:0]         o_mode
);

    logic [EXTBITS-1:0] core_ext;

    ext_core #(
        .NBITS   (NBITS),
        .EXTBITS (EXTBITS),
        .SHIFT   (SHIFT)
    ) u_ext_core (
        .i_sign (i_data),
        .i_mode (i_mode),
        .o_ext  (core_ext)
    );

    logic               out_valid_q, out_valid_d;
    logic [EXTBITS-1:0] out_ext_q,   out_ext_d;
    logic [1:0]         out_mode_q,  out_mode_d;
    logic               skid_valid_q, skid_valid_d;
    logic [EXTBITS-1:0] skid_ext_q,   skid_ext_d;
    logic [1:0]         skid_mode_q,  skid_mode_d;
    logic               ready_q,      ready_d;

    logic accept;
    logic deliver;

    assign accept  = i_valid & ready_q;
    assign deliver = out_valid_q & i_ready;

    always_comb begin
        // NOTE: every next-state signal starts from its current value so that no
        // branch leaves it unassigned; this is what keeps latches from being inferred.
        out_valid_d  = out_valid_q;
        out_ext_d    = out_ext_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_ext_d   = skid_ext_q;
        skid_mode_d  = skid_mode_q;
        ready_d      = ready_q;

        if (i_flush) begin
            // Squash everything held, and discard any simultaneous accept.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            ready_d      = 1'b1;
        end else if (skid_valid_q) begin
            // FULL: o_ready is low, so only a drain can happen.
            if (deliver) begin
                out_ext_d    = skid_ext_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
                ready_d      = 1'b1;
            end
        end else if (accept) begin
            if (!out_valid_q || deliver) begin
                out_valid_d = 1'b1;
                out_ext_d   = core_ext;
                out_mode_d  = i_mode;
            end else begin
                // OUT is stalled: park the new item and stop accepting.
                skid_valid_d = 1'b1;
                skid_ext_d   = core_ext;
                skid_mode_d  = i_mode;
                ready_d      = 1'b0;
            end
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the payload registers are reset as well as the valid bits, so
            // o_ext/o_mode read as zero after reset and no held data survives.
            out_valid_q  <= 1'b0;
            out_ext_q    <= '0;
            out_mode_q   <= EXT_SIGN;
            skid_valid_q <= 1'b0;
            skid_ext_q   <= '0;
            skid_mode_q  <= EXT_SIGN;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ext_q    <= out_ext_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_ext_q   <= skid_ext_d;
            skid_mode_q  <= skid_mode_d;
            ready_q      <= ready_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_ext   = out_ext_q;
    assign o_mode  = out_mode_q;
    assign o_ready = ready_q;

endmodule : imm_extend_stage

// File: tb/tb_imm_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_stage
// Self-checking bench for imm_extend_stage (NBITS=16, EXTBITS=32, SHIFT=2).
// Inputs are driven on the falling edge, outputs sampled on the falling edge,
// so the DUT registers see stable inputs at every rising edge.
// -----------------------------------------------------------------------------
module tb_imm_extend_stage;

    localparam int NB = 16;
    localparam int EB = 32;
    localparam int SH = 2;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [NB-1:0] i_data;
    logic [1:0]    i_mode;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic [EB-1:0] o_ext;
    logic [1:0]    o_mode;

    imm_extend_stage #(
        .NBITS   (NB),
        .EXTBITS (EB),
        .SHIFT   (SH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_mode  (i_mode),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ext   (o_ext),
        .o_mode  (o_mode)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference extension from the mode definitions, using integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [1:0] mode, input logic [15:0] d);
        longint s;
        longint v;
        s = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
        case (mode)
            2'd0:    v = s;
            2'd1:    v = longint'(d);
            2'd2:    v = longint'(d) * 65536;
            default: v = s * 4;
        endcase
        return v[31:0];
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
    } item_t;

    vec_t  vecs[7];
    item_t sb[$];

    // Offer one item; it must be visible exactly one cycle later.
    task automatic send_one(input string name, input logic [1:0] mode,
                            input logic [15:0] data, input logic [31:0] exp);
        i_valid = 1'b1;
        i_mode  = mode;
        i_data  = data;
        @(negedge i_clk);
        check({name, "_valid"}, 32'(o_valid), 32'd1);
        check({name, "_ext"},   o_ext, exp);
        check({name, "_mode"},  32'(o_mode), 32'(mode));
    endtask

    task automatic idle(input int cycles);
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (cycles) @(negedge i_clk);
    endtask

    // Fill OUT and SKID with two items while the consumer is stalled.
    task automatic make_full(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_mode  = mode;
        i_data  = a;
        @(negedge i_clk);
        i_data  = b;
        @(negedge i_clk);
        check("full_ready_low", 32'(o_ready), 32'd0);
        check("full_out_a", o_ext, ref_ext(mode, a));
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'hF00F, 32'hFFFFF00F};
        vecs[1] = '{2'b00, 16'h000F, 32'h0000000F};
        vecs[2] = '{2'b01, 16'hF00F, 32'h0000F00F};
        vecs[3] = '{2'b10, 16'h1234, 32'h12340000};
        vecs[4] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
        vecs[5] = '{2'b11, 16'h0004, 32'h00000010};
        vecs[6] = '{2'b11, 16'h8000, 32'hFFFE0000};

        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_mode  = 2'b00;
        i_flush = 1'b0;
        i_ready = 1'b1;
        #1 i_rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ext",   o_ext, 32'd0);
        check("rst_mode",  32'(o_mode), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid_after", 32'(o_valid), 32'd0);

        // Directed vectors, streamed back to back with i_ready=1.
        for (int k = 0; k < 7; k++)
            send_one($sformatf("vec%0d", k), vecs[k].mode, vecs[k].data, vecs[k].exp);
        idle(1);
        check("vec_drain_valid", 32'(o_valid), 32'd0);

        // Backpressure: A into OUT, B into SKID, C held off until release.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_mode  = 2'b00;
        i_data  = 16'h0001;
        @(negedge i_clk);
        check("bp_a_ext", o_ext, 32'h1);
        check("bp_a_ready", 32'(o_ready), 32'd1);
        i_data = 16'h0002;
        @(negedge i_clk);
        check("bp_b_hold_ext", o_ext, 32'h1);
        check("bp_b_ready", 32'(o_ready), 32'd0);
        i_data = 16'h0003;
        @(negedge i_clk);
        check("bp_c_hold_ext", o_ext, 32'h1);
        check("bp_c_ready", 32'(o_ready), 32'd0);
        check("bp_c_valid", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_out2_ext", o_ext, 32'h2);
        check("bp_out2_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        check("bp_out3_ext", o_ext, 32'h3);
        check("bp_out3_valid", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("bp_empty_valid", 32'(o_valid), 32'd0);

        // Flush in FULL with a simultaneous offer: nothing may come out.
        make_full(2'b01, 16'h0AAA, 16'h0BBB);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h0CCC;
        @(negedge i_clk);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("flush_stays_empty", 32'(o_valid), 32'd0);
        end

        // Asynchronous reset in FULL, asserted mid-cycle.
        make_full(2'b10, 16'h5A5A, 16'h6B6B);
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_ext",   o_ext, 32'd0);
        check("arst_mode",  32'(o_mode), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        check("arst_ready", 32'(o_ready), 32'd1);
        send_one("arst_first", 2'b11, 16'h0101, 32'h00000404);
        idle(1);
        check("arst_no_stale", 32'(o_valid), 32'd0);

        // Randomized traffic against a two-entry FIFO scoreboard.
        sb.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            item_t it;
            logic  fl;
            check("rnd_valid", 32'(o_valid), 32'(sb.size() != 0));
            check("rnd_ready", 32'(o_ready), 32'(sb.size() < 2));
            if (sb.size() != 0) begin
                check("rnd_ext",  o_ext, ref_ext(sb[0].mode, sb[0].data));
                check("rnd_mode", 32'(o_mode), 32'(sb[0].mode));
            end
            it.mode = 2'($urandom);
            it.data = 16'($urandom);
            fl      = ($urandom_range(0, 31) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = fl;
            i_mode  = it.mode;
            i_data  = it.data;
            if (fl) begin
                sb.delete();
            end else begin
                if (o_valid && i_ready) void'(sb.pop_front());
                if (i_valid && o_ready) sb.push_back(it);
            end
            @(negedge i_clk);
        end
        idle(3);
        check("rnd_end_valid", 32'(o_valid), 32'(sb.size() > 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imm_extend_stage
